// File: rtl/gpgpu_axi_bram_slave.sv
// gpgpu_axi_bram_slave: AXI4 slave backed by a read-first BRAM, one write and one read burst in flight
module gpgpu_axi_bram_slave #(
   parameter int DATA_W = 64,
   parameter int ID_W = 4,
   parameter int ADDR_W = 32,
   parameter int MEM_WORDS = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [ID_W-1:0]     s_axi_awid,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]          s_axi_awlen,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wlast,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic [ID_W-1:0]     s_axi_bid,
   output logic [1:0]          s_axi_bresp,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   input  logic [ID_W-1:0]     s_axi_arid,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic [7:0]          s_axi_arlen,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [ID_W-1:0]     s_axi_rid,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rlast
);
   localparam int NB = DATA_W / 8;
   localparam int SH = $clog2(NB);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   // A burst is rejected up front if any of its beats would fall outside the array
   function automatic logic range_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
      logic [ADDR_W:0] last;
      last = {1'b0, (addr - BASE_ADDR) >> SH} + {{(ADDR_W-7){1'b0}}, len};
      return (addr < BASE_ADDR) || (last >= (ADDR_W+1)'(MEM_WORDS));
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return AW'((addr - BASE_ADDR) >> SH);
   endfunction

   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic [DATA_W-1:0] r_q;

   w_state_t w_state, w_next;
   logic [ID_W-1:0] w_id;
   logic [AW-1:0] w_idx;
   logic [7:0] w_len, w_beat;
   logic w_dec, w_slv, aw_hs, w_hs;

   r_state_t r_state, r_next;
   logic [ID_W-1:0] r_id;
   logic [AW-1:0] r_idx;
   logic [7:0] r_len, r_beat;
   logic r_dec, ar_hs, r_hs;

   assign s_axi_awready = w_state == W_IDLE;
   assign s_axi_wready  = w_state == W_DATA;
   assign s_axi_bvalid  = w_state == W_RESP;
   assign s_axi_bid     = w_id;
   assign s_axi_bresp   = !s_axi_bvalid ? 2'd0 : w_dec ? 2'd3 : w_slv ? 2'd2 : 2'd0;
   assign aw_hs = s_axi_awready && s_axi_awvalid;
   assign w_hs  = s_axi_wready && s_axi_wvalid;

   assign s_axi_arready = r_state == R_IDLE;
   assign s_axi_rvalid  = r_state == R_DATA;
   assign s_axi_rid     = r_id;
   assign s_axi_rlast   = s_axi_rvalid && (r_beat == r_len);
   assign s_axi_rresp   = (s_axi_rvalid && r_dec) ? 2'd3 : 2'd0;
   assign s_axi_rdata   = (s_axi_rvalid && !r_dec) ? r_q : '0;
   assign ar_hs = s_axi_arready && s_axi_arvalid;
   assign r_hs  = s_axi_rvalid && s_axi_rready;

   // Nonblocking read and write of the same word give read-first behaviour
   always_ff @(posedge clock) begin
      if (w_hs && !w_dec)
         for (int b = 0; b < NB; b++)
            if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      if (r_state == R_FETCH) r_q <= mem[r_idx];
   end

   always_comb begin
      w_next = (w_state == W_IDLE && s_axi_awvalid) ? W_DATA :
               (w_hs && w_beat == w_len)            ? W_RESP :
               (w_state == W_RESP && s_axi_bready)  ? W_IDLE : w_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_dec   <= 1'b0;
         w_slv   <= 1'b0;
      end else begin
         w_state <= w_next;
         if (aw_hs) begin
            w_id   <= s_axi_awid;
            w_idx  <= word_idx(s_axi_awaddr);
            w_len  <= s_axi_awlen;
            w_beat <= '0;
            w_dec  <= range_err(s_axi_awaddr, s_axi_awlen);
            w_slv  <= 1'b0;
         end
         if (w_hs) begin
            w_idx  <= w_idx + AW'(1);
            w_beat <= w_beat + 8'd1;
            if (s_axi_wlast != (w_beat == w_len)) w_slv <= 1'b1;
         end
      end
   end

   always_comb begin
      r_next = (r_state == R_IDLE && s_axi_arvalid) ? R_FETCH :
               (r_state == R_FETCH)                 ? R_DATA  :
               r_hs ? (s_axi_rlast ? R_IDLE : R_FETCH) : r_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_dec   <= 1'b0;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            r_id   <= s_axi_arid;
            r_idx  <= word_idx(s_axi_araddr);
            r_len  <= s_axi_arlen;
            r_beat <= '0;
            r_dec  <= range_err(s_axi_araddr, s_axi_arlen);
         end
         if (r_hs && !s_axi_rlast) begin
            r_idx  <= r_idx + AW'(1);
            r_beat <= r_beat + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_gpgpu_axi_bram_slave.sv
// tb_gpgpu_axi_bram_slave: directed and random bursts checked against a word-array model of the memory
module tb_gpgpu_axi_bram_slave;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic s_axi_awvalid = 1'b0, s_axi_awready;
   logic [3:0] s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0] s_axi_awlen = '0;
   logic s_axi_wvalid = 1'b0, s_axi_wready;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0] s_axi_wstrb = '0;
   logic s_axi_wlast = 1'b0;
   logic s_axi_bvalid, s_axi_bready = 1'b0;
   logic [3:0] s_axi_bid;
   logic [1:0] s_axi_bresp;
   logic s_axi_arvalid = 1'b0, s_axi_arready;
   logic [3:0] s_axi_arid = '0;
   logic [31:0] s_axi_araddr = '0;
   logic [7:0] s_axi_arlen = '0;
   logic s_axi_rvalid, s_axi_rready = 1'b0;
   logic [3:0] s_axi_rid;
   logic [63:0] s_axi_rdata;
   logic [1:0] s_axi_rresp;
   logic s_axi_rlast;

   gpgpu_axi_bram_slave dut (
      .clock(clock), .reset(reset),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
      .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [63:0] ref_mem [0:4095];
   logic [63:0] wbuf [0:255];
   logic [63:0] last_rdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input int widx, input logic [7:0] strb, input logic [63:0] d);
      for (int k = 0; k < 8; k++)
         if (strb[k]) ref_mem[widx][k*8 +: 8] = d[k*8 +: 8];
   endtask

   // last_at: beat index carrying wlast, or -1 for none
   task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                     input logic [7:0] strb, input int last_at);
      bit dec;
      int widx, n;
      logic [1:0] eb;
      widx = int'(addr >> 3);
      dec = (widx + int'(len)) >= 4096;
      eb = dec ? 2'd3 : (last_at != int'(len)) ? 2'd2 : 2'd0;
      @(negedge clock);
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id;
      chk("awready", 64'(s_axi_awready), 64'd1);
      @(negedge clock);
      s_axi_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = strb; s_axi_wlast = (b == last_at);
         n = 0;
         while (!s_axi_wready && n < 20) begin @(negedge clock); n++; end
         chk("wready", 64'(s_axi_wready), 64'd1);
         @(negedge clock);
         if (!dec) model_write(widx + b, strb, wbuf[b]);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      chk("bvalid", 64'(s_axi_bvalid), 64'd1);
      chk("bid", 64'(s_axi_bid), 64'(id));
      chk("bresp", 64'(s_axi_bresp), 64'(eb));
      s_axi_bready = 1'b1;
      @(negedge clock);
      s_axi_bready = 1'b0;
      chk("awready_ret", 64'(s_axi_awready), 64'd1);
      chk("bvalid_clr", 64'(s_axi_bvalid), 64'd0);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, input bit rnd);
      bit dec;
      int widx, n;
      logic [63:0] exp_d;
      widx = int'(addr >> 3);
      dec = (widx + int'(len)) >= 4096;
      @(negedge clock);
      s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id;
      chk("arready", 64'(s_axi_arready), 64'd1);
      @(negedge clock);
      s_axi_arvalid = 1'b0;
      chk("rvalid_early", 64'(s_axi_rvalid), 64'd0);
      @(negedge clock);
      chk("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
      for (int b = 0; b <= int'(len); b++) begin
         n = 0;
         while (!s_axi_rvalid && n < 20) begin @(negedge clock); n++; end
         exp_d = dec ? 64'd0 : ref_mem[widx + b];
         chk("rvalid", 64'(s_axi_rvalid), 64'd1);
         chk("rdata", s_axi_rdata, exp_d);
         chk("rresp", 64'(s_axi_rresp), dec ? 64'd3 : 64'd0);
         chk("rid", 64'(s_axi_rid), 64'(id));
         chk("rlast", 64'(s_axi_rlast), 64'(b == int'(len)));
         last_rdata = s_axi_rdata;
         s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         n = 0;
         while (!s_axi_rready) begin
            @(negedge clock);
            chk("rvalid_stall", 64'(s_axi_rvalid), 64'd1);
            chk("rdata_stall", s_axi_rdata, exp_d);
            chk("rlast_stall", 64'(s_axi_rlast), 64'(b == int'(len)));
            n++;
            s_axi_rready = (n > 6) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         s_axi_rready = 1'b0;
      end
      chk("arready_ret", 64'(s_axi_arready), 64'd1);
      chk("rvalid_clr", 64'(s_axi_rvalid), 64'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, l;
      repeat (3) @(negedge clock);
      chk("rst_awready", 64'(s_axi_awready), 64'd1);
      chk("rst_arready", 64'(s_axi_arready), 64'd1);
      chk("rst_wready", 64'(s_axi_wready), 64'd0);
      chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
      chk("rst_bid", 64'(s_axi_bid), 64'd0);
      chk("rst_rid", 64'(s_axi_rid), 64'd0);
      chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
      chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
      chk("rst_rdata", s_axi_rdata, 64'd0);
      reset = 1'b0;
      // T1/T2: aligned 4-beat write then read back
      for (int b = 0; b < 4; b++) wbuf[b] = 64'hD0D0_0000_0000_0000 + 64'(b) * 64'h0101_0101;
      wr(32'h40, 8'd3, 4'd5, 8'hFF, 3);
      rd(32'h40, 8'd3, 4'd9, 1'b0);
      // T3: byte-lane merge
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      wr(32'h100, 8'd0, 4'd1, 8'hFF, 0);
      wbuf[0] = 64'h1122_3344_5566_7788;
      wr(32'h100, 8'd0, 4'd2, 8'h0F, 0);
      rd(32'h100, 8'd0, 4'd3, 1'b0);
      chk("t3_merge", last_rdata, 64'hFFFF_FFFF_5566_7788);
      // T4: bursts that run off the top of the array
      for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
      wr(32'h7FF0, 8'd1, 4'd3, 8'hFF, 1);
      for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
      wr(32'h7FF0, 8'd3, 4'd4, 8'hFF, 3);
      rd(32'h7FF0, 8'd3, 4'd6, 1'b0);
      rd(32'h7FF0, 8'd1, 4'd7, 1'b1);
      // T5: wlast misplaced or missing, random read stalls
      for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
      wr(32'h200, 8'd3, 4'd2, 8'hFF, 1);
      for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
      wr(32'h300, 8'd3, 4'd8, 8'hFF, -1);
      rd(32'h200, 8'd3, 4'd10, 1'b1);
      rd(32'h300, 8'd3, 4'd11, 1'b1);
      // T6: reset in the middle of a write burst
      @(negedge clock);
      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h400; s_axi_awlen = 8'd3; s_axi_awid = 4'd12;
      @(negedge clock);
      s_axi_awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         wbuf[b] = {$urandom, $urandom};
         s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
         @(negedge clock);
         model_write(128 + b, 8'hFF, wbuf[b]);
      end
      s_axi_wvalid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      chk("t6_awready", 64'(s_axi_awready), 64'd1);
      chk("t6_bvalid", 64'(s_axi_bvalid), 64'd0);
      chk("t6_wready", 64'(s_axi_wready), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("t6_bvalid_after", 64'(s_axi_bvalid), 64'd0);
      rd(32'h400, 8'd1, 4'd13, 1'b0);
      // random region: fill words 512..639, then mix partial writes and stalled reads
      for (int i = 0; i < 32; i++) begin
         for (int b = 0; b < 4; b++) wbuf[b] = {$urandom, $urandom};
         wr(32'((512 + i * 4) * 8), 8'd3, 4'($urandom), 8'hFF, 3);
      end
      for (int i = 0; i < 40; i++) begin
         a = 512 + int'($urandom_range(0, 119));
         l = int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b <= l; b++) wbuf[b] = {$urandom, $urandom};
            wr(32'(a * 8), 8'(l), 4'($urandom), 8'($urandom), l);
         end else begin
            rd(32'(a * 8), 8'(l), 4'($urandom), 1'b1);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
